spi_ram_burst: RTL and testbench

Parametrised command-decoded single-port RAM behind the SPI slave's parallel interface. It decodes 2-bit-opcode command words from the SPI receive path into address loads, writes, and burst reads. It has separate auto-incrementing write and read pointers. Read data returns to the SPI transmit path over a valid/ready handshake with backpressure.

---
 rtl/spi_ram_pkg.sv | 21 ++
 rtl/sp_ram_core.sv | 24 ++
 rtl/spi_ram_burst.sv | 110 +++++++++++
 tb/tb_spi_ram_burst.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared opcodes, FSM state type and parameter helper for the SPI-attached burst RAM.
package spi_ram_pkg;

  localparam logic [1:0] OP_WR_ADDR  = 2'b00;
  localparam logic [1:0] OP_WR_DATA  = 2'b01;
  localparam logic [1:0] OP_RD_ADDR  = 2'b10;
  localparam logic [1:0] OP_RD_BURST = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2
  } state_e;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sp_ram_core.sv
// Single-port RAM with registered read; the array itself is never reset.
module sp_ram_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/spi_ram_burst.sv
// Command decoder, write/read pointers and burst-read FSM in front of a single-port RAM.
module spi_ram_burst
  import spi_ram_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 4,
  localparam int unsigned P_W   = max3(ADDR_W, DATA_W, LEN_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [P_W+1:0]     rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic [DATA_W-1:0]  tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LEN_W:0]    remaining_q, remaining_d;

  logic [1:0]        opcode;
  logic [P_W-1:0]    payload;
  logic              cmd_acc;
  logic              we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] rdata;

  assign opcode   = rx_data[P_W+1:P_W];
  assign payload  = rx_data[P_W-1:0];
  assign rx_ready = (state_q == IDLE) && !rst;
  assign cmd_acc  = rx_valid && rx_ready;
  assign we       = cmd_acc && (opcode == OP_WR_DATA);
  assign busy     = (state_q != IDLE);
  assign tx_valid = (state_q == PRESENT);
  assign tx_data  = tx_valid ? rdata : '0;

  // While presenting, keep re-reading the word just fetched so rdata holds through a stall.
  always_comb begin
    ram_addr = rd_ptr_q;
    if (state_q == PRESENT) begin
      ram_addr = rd_ptr_q - ADDR_W'(1);
    end else if (we) begin
      ram_addr = wr_ptr_q;
    end
  end

  sp_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .addr  (ram_addr),
    .wdata (payload[DATA_W-1:0]),
    .rdata (rdata)
  );

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (cmd_acc) begin
          case (opcode)
            OP_WR_ADDR: wr_ptr_d = payload[ADDR_W-1:0];
            OP_WR_DATA: wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            OP_RD_ADDR: rd_ptr_d = payload[ADDR_W-1:0];
            default: begin
              remaining_d = {1'b0, payload[LEN_W-1:0]} + (LEN_W + 1)'(1);
              state_d     = FETCH;
            end
          endcase
        end
      end
      FETCH: begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        state_d  = PRESENT;
      end
      PRESENT: begin
        if (tx_ready) begin
          remaining_d = remaining_q - (LEN_W + 1)'(1);
          state_d     = (remaining_q == (LEN_W + 1)'(1)) ? IDLE : FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
    end
  end

endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench for spi_ram_burst with a read-data scoreboard fed from a memory model.
module tb_spi_ram_burst;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned P_W    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [P_W+1:0]    rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;

  always #5 clk = ~clk;

  spi_ram_burst #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy)
  );

  int errors = 0;
  int checks = 0;
  int words_seen = 0;
  int base;

  logic [7:0] model_mem [256];
  logic [7:0] m_wr, m_rd;
  logic [7:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    assert (obs === expd) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expd);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one command for a single cycle and update the reference model.
  task automatic send(input logic [1:0] op, input logic [7:0] pl);
    chk("cmd_rx_ready", rx_ready, 1);
    rx_data  = {op, pl};
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    case (op)
      2'b00: m_wr = pl;
      2'b01: begin
        model_mem[m_wr] = pl;
        m_wr++;
      end
      2'b10: m_rd = pl;
      default: begin
        for (int i = 0; i <= int'(pl[3:0]); i++) begin
          exp_q.push_back(model_mem[m_rd]);
          m_rd++;
        end
      end
    endcase
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      step();
    end
    chk("idle_timeout", busy, 0);
  endtask

  // Every accepted word is scored against the queue front.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      words_seen++;
      chk("queue_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("tx_data", tx_data, exp_q.pop_front());
    end
  end

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    tx_ready = 1'b1;
    m_wr     = '0;
    m_rd     = '0;
    repeat (3) step();
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_data", tx_data, 0);
    rst = 1'b0;
    step();
    chk("post_rst_rx_ready", rx_ready, 1);
    chk("post_rst_wr_ptr", dut.wr_ptr_q, 0);
    chk("post_rst_rd_ptr", dut.rd_ptr_q, 0);

    // Writes and a 2-word burst with cycle-exact latency checks.
    send(2'b00, 8'h10);
    send(2'b01, 8'hA5);
    send(2'b01, 8'h5A);
    chk("wr_ptr_after_writes", dut.wr_ptr_q, 8'h12);
    send(2'b10, 8'h10);
    send(2'b11, 8'h01);
    chk("lat_fetch_valid", tx_valid, 0);
    chk("lat_fetch_busy", busy, 1);
    chk("lat_fetch_rx_ready", rx_ready, 0);
    step();
    chk("lat_word1_valid", tx_valid, 1);
    step();
    chk("lat_bubble_valid", tx_valid, 0);
    step();
    chk("lat_word2_valid", tx_valid, 1);
    step();
    chk("lat_end_busy", busy, 0);
    chk("lat_end_rx_ready", rx_ready, 1);
    chk("lat_end_tx_valid", tx_valid, 0);
    chk("lat_end_queue", exp_q.size(), 0);

    // Pointer wrap from 0xFF to 0x00.
    send(2'b00, 8'hFF);
    send(2'b01, 8'h11);
    send(2'b01, 8'h22);
    chk("wrap_wr_ptr", dut.wr_ptr_q, 8'h01);
    send(2'b10, 8'hFF);
    send(2'b11, 8'h01);
    wait_idle();
    chk("wrap_queue", exp_q.size(), 0);

    // Stall on word 2 while a write is offered and must be ignored.
    send(2'b00, 8'h12);
    send(2'b01, 8'hC3);
    send(2'b01, 8'h3C);
    send(2'b00, 8'h20);
    send(2'b01, 8'h33);
    send(2'b00, 8'h20);
    base = words_seen;
    send(2'b10, 8'h10);
    send(2'b11, 8'h03);
    for (int i = 0; i < 20 && words_seen < base + 1; i++) step();
    chk("stall_word1_seen", words_seen - base, 1);
    tx_ready = 1'b0;
    rx_data  = {2'b01, 8'hEE};
    rx_valid = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", tx_valid, 1);
      chk("stall_data", tx_data, exp_q[0]);
      chk("stall_rx_ready", rx_ready, 0);
      step();
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    chk("stall_wr_ptr", dut.wr_ptr_q, 8'h20);
    wait_idle();
    chk("stall_word_count", words_seen - base, 4);
    chk("stall_queue", exp_q.size(), 0);
    repeat (2) step();
    chk("stall_after_valid", tx_valid, 0);

    // Single-word burst; also shows the ignored write left 0x20 intact.
    base = words_seen;
    send(2'b10, 8'h20);
    send(2'b11, 8'h00);
    wait_idle();
    chk("len0_word_count", words_seen - base, 1);

    // Upper payload bits above the length field are ignored.
    base = words_seen;
    send(2'b10, 8'h10);
    send(2'b11, 8'hF3);
    wait_idle();
    chk("lenF3_word_count", words_seen - base, 4);
    chk("lenF3_queue", exp_q.size(), 0);

    // Reset in the middle of a 16-word burst.
    send(2'b00, 8'h30);
    for (int i = 0; i < 16; i++) send(2'b01, 8'(i * 7 + 3));
    send(2'b10, 8'h30);
    base = words_seen;
    send(2'b11, 8'h0F);
    for (int i = 0; i < 100 && words_seen < base + 3; i++) step();
    chk("abort_words_before", words_seen - base, 3);
    rst = 1'b1;
    step();
    chk("abort_tx_valid", tx_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rx_ready", rx_ready, 0);
    chk("abort_wr_ptr", dut.wr_ptr_q, 0);
    chk("abort_rd_ptr", dut.rd_ptr_q, 0);
    chk("abort_remaining", dut.remaining_q, 0);
    chk("abort_word_count", words_seen - base, 3);
    exp_q.delete();
    m_wr = '0;
    m_rd = '0;
    rst  = 1'b0;
    step();
    chk("abort_rx_ready_back", rx_ready, 1);
    base = words_seen;
    send(2'b10, 8'h30);
    send(2'b11, 8'h02);
    wait_idle();
    chk("abort_reread_count", words_seen - base, 3);
    chk("abort_reread_queue", exp_q.size(), 0);
    base = words_seen;
    send(2'b10, 8'h10);
    send(2'b11, 8'h01);
    wait_idle();
    chk("abort_intact_count", words_seen - base, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
